// File: rtl/leq_mid_if.sv
// ============================================================================
//  Module      : leq_mid_if
//  Description : Request, child-read and downstream-request bundle for one
//                middle level of the pipelined heap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface leq_mid_if #(
   parameter int LEVELS = 4,
   parameter int LEVEL  = 2
);
   localparam int c_AW = LEVEL - 1;
   localparam int c_PW = (LEVEL > 2) ? (LEVEL - 2) : 1;
   localparam int c_EW = 32 + LEVELS + 1;

   // Request from the upstream stage
   logic              start;
   logic              op;
   logic [c_AW-1:0]   addr;
   logic [31:0]       in;
   // Upstream child-pair read port into this level's memory
   logic [c_PW-1:0]   rdPair;
   logic [c_EW-1:0]   rdL;
   logic [c_EW-1:0]   rdR;
   // Child-pair read into the downstream level
   logic [c_AW-1:0]   raddrBot;
   logic [c_EW-1:0]   rBotL;
   logic [c_EW-1:0]   rBotR;
   // Status and downstream request
   logic [1:0]        done;
   logic              ready;
   logic              startOut;
   logic              opOut;
   logic [LEVEL-1:0]  addrOut;
   logic [31:0]       outVal;
   logic              overflow;

   modport master (
      output start, op, addr, in, rdPair, rBotL, rBotR,
      input  rdL, rdR, raddrBot, done, ready, startOut, opOut, addrOut,
             outVal, overflow
   );

   modport slave (
      input  start, op, addr, in, rdPair, rBotL, rBotR,
      output rdL, rdR, raddrBot, done, ready, startOut, opOut, addrOut,
             outVal, overflow
   );
endinterface

`default_nettype wire

// File: rtl/leq_mid.sv
// ============================================================================
//  Module      : leq_mid
//  Description : Middle heap level stage. Holds 2^(LEVEL-1) entries, performs
//                a three-cycle IDLE/READ/EXEC enqueue or dequeue step on one
//                node and forwards the displaced value or the refill request
//                to the next level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leq_mid #(
   parameter int LEVELS = 4,
   parameter int LEVEL  = 2
) (
   input  logic      clk,
   input  logic      rst,
   leq_mid_if.slave  bus
);

   localparam int c_AW    = LEVEL - 1;
   localparam int c_DEPTH = 1 << c_AW;

   localparam logic       c_OP_LEQ = 1'b0;
   localparam logic       c_OP_DEQ = 1'b1;
   localparam logic [1:0] c_DONE   = 2'd0;
   localparam logic [1:0] c_WAIT   = 2'd1;
   localparam logic [1:0] c_NEXT   = 2'd2;

   // Capacity of an empty node: number of free slots in the subtree rooted here
   localparam logic [LEVELS-1:0] c_CAP_MAX  = LEVELS'((1 << (LEVELS - LEVEL + 1)) - 1);
   localparam logic [LEVELS-1:0] c_CAP_ONE  = LEVELS'(1);
   localparam logic [LEVELS-1:0] c_CAP_ZERO = '0;

   typedef struct packed {
      logic [31:0]       prio;
      logic [LEVELS-1:0] cap;
      logic              act;
   } entry_t;

   localparam entry_t c_ENTRY_RST = '{prio: 32'd0, cap: c_CAP_MAX, act: 1'b0};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   entry_t           r_mem [c_DEPTH];

   logic             r_op;
   logic [c_AW-1:0]  r_addr;
   logic [31:0]      r_in;
   entry_t           r_e;
   entry_t           r_botL;
   entry_t           r_botR;

   logic             r_startOut;
   logic             r_opOut;
   logic [LEVEL-1:0] r_addrOut;
   logic [31:0]      r_outVal;

   entry_t           w_botL;
   entry_t           w_botR;
   entry_t           w_wr;
   logic [1:0]       w_exec_done;
   logic             w_req;
   logic             w_sel;
   logic             w_ovf;
   logic [31:0]      w_val_out;
   logic [31:0]      w_hi;
   logic [31:0]      w_lo;
   logic [LEVELS-1:0] w_cap_dec;
   logic [LEVELS-1:0] w_cap_inc;
   logic [1:0]       w_done;
   logic             w_ready;

   // Upstream read port; the root-children level has a single pair
   generate
      if (LEVEL == 2) begin : g_pair_single
         wire w_unused_rdpair = ^bus.rdPair;
         assign bus.rdL = r_mem[0];
         assign bus.rdR = r_mem[1];
      end else begin : g_pair_indexed
         assign bus.rdL = r_mem[{bus.rdPair, 1'b0}];
         assign bus.rdR = r_mem[{bus.rdPair, 1'b1}];
      end
   endgenerate

   // The last level has no children below it
   generate
      if (LEVEL == LEVELS) begin : g_leaf
         wire w_unused_bot = ^{bus.rBotL, bus.rBotR};
         assign w_botL = '0;
         assign w_botR = '0;
      end else begin : g_inner
         assign w_botL = entry_t'(bus.rBotL);
         assign w_botR = entry_t'(bus.rBotR);
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // FSM next state and status outputs
   always_comb begin
      w_next  = r_state;
      w_done  = c_DONE;
      w_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.start) w_next = S_READ;
         end
         S_READ: begin
            w_done = c_WAIT;
            w_next = S_EXEC;
         end
         S_EXEC: begin
            w_done = w_exec_done;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture the request; starts outside IDLE are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op   <= c_OP_LEQ;
         r_addr <= '0;
         r_in   <= '0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_op   <= bus.op;
         r_addr <= bus.addr;
         r_in   <= bus.in;
      end
   end

   // Snapshot the node and its two children at the end of READ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e    <= '0;
         r_botL <= '0;
         r_botR <= '0;
      end else if (r_state == S_READ) begin
         r_e    <= r_mem[r_addr];
         r_botL <= w_botL;
         r_botR <= w_botR;
      end
   end

   // EXEC datapath: new node value, completion code and child selection
   always_comb begin
      w_exec_done = c_DONE;
      w_wr        = r_e;
      w_req       = 1'b0;
      w_sel       = 1'b0;
      w_ovf       = 1'b0;
      w_val_out   = '0;
      w_hi        = (r_in > r_e.prio) ? r_in : r_e.prio;
      w_lo        = (r_in > r_e.prio) ? r_e.prio : r_in;
      w_cap_dec   = (r_e.cap != c_CAP_ZERO) ? (r_e.cap - c_CAP_ONE) : r_e.cap;
      w_cap_inc   = (r_e.cap < c_CAP_MAX) ? (r_e.cap + c_CAP_ONE) : c_CAP_MAX;
      if (r_op == c_OP_LEQ) begin
         if (!r_e.act) begin
            w_wr = '{prio: r_in, cap: w_cap_dec, act: 1'b1};
         end else if (r_e.cap != c_CAP_ZERO) begin
            w_wr        = '{prio: w_hi, cap: w_cap_dec, act: 1'b1};
            w_val_out   = w_lo;
            w_req       = 1'b1;
            w_exec_done = c_NEXT;
            // Push toward the subtree with room; smaller key when both have room
            if (r_botL.cap != c_CAP_ZERO && r_botR.cap != c_CAP_ZERO)
               w_sel = (r_botR.prio < r_botL.prio);
            else
               w_sel = (r_botL.cap == c_CAP_ZERO) && (r_botR.cap != c_CAP_ZERO);
         end else begin
            // Subtree full: the smaller key is lost
            w_wr  = '{prio: w_hi, cap: r_e.cap, act: 1'b1};
            w_ovf = 1'b1;
         end
      end else begin
         if (!r_botL.act && !r_botR.act) begin
            w_wr = '{prio: 32'd0, cap: w_cap_inc, act: 1'b0};
         end else begin
            if (!r_botR.act)      w_sel = 1'b0;
            else if (!r_botL.act) w_sel = 1'b1;
            else                  w_sel = (r_botR.prio > r_botL.prio);
            w_wr        = '{prio: (w_sel ? r_botR.prio : r_botL.prio),
                            cap: w_cap_inc, act: 1'b1};
            w_req       = 1'b1;
            w_exec_done = c_NEXT;
         end
      end
   end

   // Node memory: reset to empty, written once at the end of EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= c_ENTRY_RST;
      end else if (r_state == S_EXEC) begin
         r_mem[r_addr] <= w_wr;
      end
   end

   // Downstream request register, startOut pulses for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_startOut <= 1'b0;
         r_opOut    <= c_OP_LEQ;
         r_addrOut  <= '0;
         r_outVal   <= '0;
      end else begin
         r_startOut <= (r_state == S_EXEC) && w_req;
         if (r_state == S_EXEC && w_req) begin
            r_opOut   <= r_op;
            r_addrOut <= {r_addr, w_sel};
            r_outVal  <= (r_op == c_OP_DEQ) ? 32'd0 : w_val_out;
         end
      end
   end

   assign bus.raddrBot = r_addr;
   assign bus.done     = w_done;
   assign bus.ready    = w_ready;
   assign bus.startOut = r_startOut;
   assign bus.opOut    = r_opOut;
   assign bus.addrOut  = r_addrOut;
   assign bus.outVal   = r_outVal;
   assign bus.overflow = (r_state == S_EXEC) && w_ovf;

endmodule

`default_nettype wire

// File: doc/leq_mid.md
LEQ_MID -- requirements
Module: leq_mid

Interface
REQ-001 Parameter LEVELS, default 4, meaning total heap levels; entry_t capacity field is LEVELS bits.
REQ-002 Parameter LEVEL, default 2, meaning this stage's level number, legal range 2..LEVELS.
REQ-003 Local memory SHALL hold 2^(LEVEL-1) pheapTypes::entry_t entries {priorityValue[31:0], capacity, active}.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request pulse from upstream stage, meaning its done==NEXT_LEVEL.
REQ-007 op  in  opcode_t  LEQ (enqueue) or DEQ.
REQ-008 addr  in  LEVEL-1  node index in this level.
REQ-009 in  in  32  value pushed down on LEQ; ignored on DEQ.
REQ-010 rdPair  in  max(LEVEL-2,1)  upstream child-pair read address; ignored when LEVEL==2.
REQ-011 rdL, rdR  out  entry_t  combinational mem[{rdPair,0}], mem[{rdPair,1}].
REQ-012 raddrBot  out  LEVEL-1  child-pair address to the downstream level.
REQ-013 rBotL, rBotR  in  entry_t  downstream children; when LEVEL==LEVELS, treated as {0,0,0}.
REQ-014 done  out  done_t  DONE, WAIT or NEXT_LEVEL.
REQ-015 ready  out  1  high only in IDLE.
REQ-016 startOut, opOut, addrOut[LEVEL-1:0], outVal[31:0]  out  registered request to the downstream stage.
REQ-017 overflow  out  1  one-cycle pulse when an enqueue value is dropped.

Function
REQ-018 FSM states SHALL be IDLE, READ and EXEC; transitions: IDLE->READ on start, READ->EXEC, EXEC->IDLE unconditionally.
REQ-019 start outside IDLE SHALL be ignored, with no effect on state or memory.
REQ-020 On the IDLE start edge, the stage SHALL latch op, addr and in.
REQ-021 READ: done=WAIT, raddrBot=latched addr; e=mem[addr], rBotL and rBotR SHALL be registered at end of READ.
REQ-022 EXEC: done per REQ-023..REQ-026; memory write committed at end of EXEC; startOut etc. registered at that edge.
REQ-023 LEQ, e inactive: the stage SHALL write {in, e.capacity-1, 1}, done=DONE, and issue no downstream request.
REQ-024 LEQ, e active, capacity>0: write {max(e.priorityValue,in), e.capacity-1, 1}; outVal=min; done=NEXT_LEVEL.
REQ-025 LEQ child select: both child capacity!=0 -> lower priorityValue, tie left; else the nonzero child, left preferred.
REQ-026 LEQ, e active, capacity==0: keep max, drop min, done=DONE, pulse overflow in the EXEC cycle, no downstream request.
REQ-027 DEQ, both children inactive: the stage SHALL write {0, e.capacity+1, 0}, done=DONE, and issue no downstream request.
REQ-028 DEQ otherwise: an inactive child always loses; pick larger priorityValue, tie left; write {winner.priorityValue, e.capacity+1, 1}; done=NEXT_LEVEL.
REQ-029 Downstream request: startOut high exactly one cycle, the cycle after EXEC; opOut=op; addrOut={addr, sel}, sel 0=left 1=right.
REQ-030 Capacity arithmetic SHALL be LEVELS bits; LEQ decrement only when capacity>0; DEQ increment never exceeds the reset value.
REQ-031 Latency: start edge to startOut SHALL be 3 cycles; throughput SHALL be one operation per 3 cycles; ready returns in the startOut cycle.
REQ-032 rdL/rdR SHALL reflect a write from the cycle after it commits; no same-cycle bypass.
REQ-033 done SHALL be DONE in IDLE.

Reset
REQ-034 rst SHALL act immediately, mid-operation included: state=IDLE and latched op/addr/in discarded.
REQ-035 Reset output values SHALL be done=DONE, ready=1, startOut=0, opOut=LEQ, addrOut=0, outVal=0, overflow=0.
REQ-036 On reset, every memory entry SHALL be {0, 2^(LEVELS-LEVEL+1)-1, 0}.

Verification (LEVELS=3, LEVEL=2, leaf capacity 1)
REQ-037 The bench SHALL cover reset: pulse rst -> rdL=rdR={0,3,0}, done=DONE, ready=1.
REQ-038 The bench SHALL cover LEQ addr=0 in=5 into empty node -> EXEC done=DONE, then rdL={5,2,1}, no startOut.
REQ-039 The bench SHALL cover LEQ in=9 onto {5,2,1} with leaf children {0,1,0} -> node {9,1,1}, startOut cycle 3, addrOut=00, outVal=5, done=NEXT_LEVEL.
REQ-040 The bench SHALL cover DEQ on {9,0,1} with children {3,0,1}, {7,0,1} -> node {7,1,1}, opOut=DEQ, addrOut=01.
REQ-041 The bench SHALL cover DEQ on {4,2,1} with both children inactive -> node {0,3,0}, done=DONE, no startOut.
REQ-042 The bench SHALL cover LEQ in=4 onto {6,0,1} -> node {6,0,1}, overflow pulse; also rst during READ -> no startOut, memory reinitialised.
